// File: rtl/my_stack_mc.sv
// Multi-channel register-based LIFO: NUM_CH stacks of DEPTH entries behind one push and one pop port.
// Optional sticky overflow/underflow flags are built when MY_STACK_MC_ERR_EN is defined.
module my_stack_mc #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_push,
  input  logic [CH_W-1:0]         i_push_ch,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  input  logic [CH_W-1:0]         i_pop_ch,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  output logic [CH_W-1:0]         o_ch,
  output logic [NUM_CH-1:0]       o_full,
  output logic [NUM_CH-1:0]       o_empty,
  output logic [NUM_CH*PTR_W-1:0] o_level,
  input  logic                    i_err_clr,
  output logic                    o_ovf_err,
  output logic                    o_unf_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  ptr     [NUM_CH];
  logic [DATA_W-1:0] mem     [NUM_CH][DEPTH];
  logic [IDX_W-1:0]  top_idx [NUM_CH];
  logic [IDX_W-1:0]  wr_idx  [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push_ok;
  logic [NUM_CH-1:0] pop_ok;
  logic [DATA_W-1:0] pop_data;

  logic [DATA_W-1:0] data_p1;
  logic [CH_W-1:0]   ch_p1;
  logic              vld_p1;

  always_comb begin
    full    = '0;
    empty   = '0;
    o_level = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]                   = (ptr[c] == PTR_W'(DEPTH));
      empty[c]                  = (ptr[c] == '0);
      o_level[c*PTR_W +: PTR_W] = ptr[c];
    end
  end

  assign o_full  = full;
  assign o_empty = empty;

  // Out-of-range channel codes match no channel, so such requests fall out as rejected.
  // A same-channel pop frees the top slot, letting a push at full overwrite it in place.
  always_comb begin
    push_ok  = '0;
    pop_ok   = '0;
    pop_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      top_idx[c] = IDX_W'(ptr[c] - PTR_W'(1));
      pop_ok[c]  = i_pop && (i_pop_ch == CH_W'(c)) && !empty[c];
      push_ok[c] = i_push && (i_push_ch == CH_W'(c)) && (!full[c] || pop_ok[c]);
      wr_idx[c]  = pop_ok[c] ? top_idx[c] : IDX_W'(ptr[c]);
      if (pop_ok[c]) pop_data = mem[c][top_idx[c]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) ptr[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case ({push_ok[c], pop_ok[c]})
          2'b10:   ptr[c] <= ptr[c] + PTR_W'(1);
          2'b01:   ptr[c] <= ptr[c] - PTR_W'(1);
          default: ptr[c] <= ptr[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c]) mem[c][wr_idx[c]] <= i_data;
    end
  end

  // ---- stage p1: registered pop result ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else begin
      vld_p1 <= |pop_ok;
      if (|pop_ok) begin
        data_p1 <= pop_data;
        ch_p1   <= i_pop_ch;
      end
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_ch    = ch_p1;

`ifdef MY_STACK_MC_ERR_EN
  logic push_rej;
  logic pop_rej;
  logic ovf_err;
  logic unf_err;

  assign push_rej = i_push && !(|push_ok);
  assign pop_rej  = i_pop && !(|pop_ok);

  // A new rejection in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (push_rej)       ovf_err <= 1'b1;
      else if (i_err_clr) ovf_err <= 1'b0;
      if (pop_rej)        unf_err <= 1'b1;
      else if (i_err_clr) unf_err <= 1'b0;
    end
  end

  assign o_ovf_err = ovf_err;
  assign o_unf_err = unf_err;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_ovf_err      = 1'b0;
  assign o_unf_err      = 1'b0;
`endif

endmodule
